// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
`timescale 1ns/1ps
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side request/ready bundle for one RAM arbiter port.
`timescale 1ns/1ps
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata
    );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the side that was not served last wins.
`timescale 1ns/1ps
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        grant = 1'b0;
        valid = |req;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM shared by two requesters, one access at a time, round-robin.
`timescale 1ns/1ps
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      m0,
    ram_arbiter_if.slave      m1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              owner
);

    localparam int            CW   = $clog2(RD_LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(RD_LATENCY - 1);

    state_t            state;
    state_t            nxt;
    logic [CW-1:0]     cnt;
    logic              gnt;
    logic              gnt_ok;
    logic              we_q;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    rr_pick2 u_pick (
        .req   ({m1.req, m0.req}),
        .last  (owner),
        .grant (gnt),
        .valid (gnt_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt      = state;
        busy     = (state != IDLE);
        m0.ready = (state == RESP) && !owner;
        m1.ready = (state == RESP) && owner;
        m0.rdata = rdata0;
        m1.rdata = rdata1;
        case (state)
            IDLE:    if (gnt_ok) nxt = ACCESS;
            ACCESS:  nxt = we_q ? RESP : WAIT;
            WAIT:    if (cnt == LAST) nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // RAM outputs are loaded on the grant edge so they are valid in ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= 1'b1;
            we_q     <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            cnt      <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_ok) begin
                        owner    <= gnt;
                        we_q     <= gnt ? m1.we : m0.we;
                        ram_we   <= gnt ? m1.we : m0.we;
                        ram_addr <= gnt ? m1.addr : m0.addr;
                        ram_din  <= gnt ? m1.wdata : m0.wdata;
                    end
                end
                ACCESS: cnt <= '0;
                WAIT: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (owner) rdata1 <= ram_dout;
                        else       rdata0 <= ram_dout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one latency-1 and one latency-3 instance.
`timescale 1ns/1ps
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a1 ();
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

    logic [AW-1:0] ram_addr, ram_addr3;
    logic          ram_we, ram_we3;
    logic [DW-1:0] ram_din, ram_din3;
    logic [DW-1:0] ram_dout, ram_dout3;
    logic          busy, busy3, owner, owner3;

    ram_arbiter #(.RD_LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .m0(a0), .m1(a1),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy), .owner(owner)
    );

    ram_arbiter #(.RD_LATENCY(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
        .clk(clk), .rst(rst), .m0(b0), .m1(b1),
        .ram_addr(ram_addr3), .ram_we(ram_we3), .ram_din(ram_din3),
        .ram_dout(ram_dout3), .busy(busy3), .owner(owner3)
    );

    // Synchronous RAM models, latency 1 and 3, with a bench preload port
    logic [DW-1:0] mem  [1024];
    logic [DW-1:0] mem3 [1024];
    logic [DW-1:0] pipe3 [3];
    logic          pl_we;
    logic          pl_sel;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_we && !pl_sel) mem[pl_addr] <= pl_data;
        else if (ram_we)      mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    always @(posedge clk) begin
        if (pl_we && pl_sel) mem3[pl_addr] <= pl_data;
        else if (ram_we3)    mem3[ram_addr3] <= ram_din3;
        pipe3[0] <= mem3[ram_addr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_dout3 = pipe3[2];

    int checks = 0;
    int errors = 0;

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic sel);
        @(negedge clk);
        pl_we = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner got %b exp 1", owner); end
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
        checks++;
        if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr got %h exp 0", ram_addr); end
        checks++;
        if (ram_din !== '0) begin errors++; $display("FAIL reset_ram_din got %h exp 0", ram_din); end
        checks++;
        if ({a0.ready, a1.ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b%b exp 00", a0.ready, a1.ready);
        end
        checks++;
        if (a0.rdata !== '0 || a1.rdata !== '0) begin
            errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", a0.rdata, a1.rdata);
        end
        checks++;
        if (owner3 !== 1'b1 || busy3 !== 1'b0) begin
            errors++; $display("FAIL reset_dut3 got owner %b busy %b exp 1 0", owner3, busy3);
        end
        rst = 1'b0;
    endtask

    task automatic test_write();
        @(negedge clk);
        a0.req = 1'b1; a0.we = 1'b1; a0.addr = 10'h005; a0.wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (ram_we !== (c == 1)) begin
                errors++; $display("FAIL wr_ram_we c%0d got %b exp %b", c, ram_we, c == 1);
            end
            if (c == 1) begin
                checks++;
                if (ram_addr !== 10'h005 || ram_din !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL wr_bus got %h/%h exp 005/deadbeef", ram_addr, ram_din);
                end
            end
            checks++;
            if (a0.ready !== (c == 2)) begin
                errors++; $display("FAIL wr_m0_ready c%0d got %b exp %b", c, a0.ready, c == 2);
            end
            checks++;
            if (a1.ready !== 1'b0) begin
                errors++; $display("FAIL wr_m1_ready c%0d got %b exp 0", c, a1.ready);
            end
            if (c == 2) a0.req = 1'b0;
        end
        checks++;
        if (mem[5] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_mem got %h exp deadbeef", mem[5]);
        end
        checks++;
        if (owner !== 1'b0) begin errors++; $display("FAIL wr_owner got %b exp 0", owner); end
    endtask

    task automatic test_read();
        preload(10'h3FF, 32'h12345678, 1'b0);
        @(negedge clk);
        a1.req = 1'b1; a1.we = 1'b0; a1.addr = 10'h3FF; a1.wdata = 32'h0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (a1.ready !== (c == 3)) begin
                errors++; $display("FAIL rd_m1_ready c%0d got %b exp %b", c, a1.ready, c == 3);
            end
            checks++;
            if (ram_we !== 1'b0 || a0.ready !== 1'b0) begin
                errors++; $display("FAIL rd_quiet c%0d got we %b m0r %b exp 0 0", c, ram_we, a0.ready);
            end
            if (c == 2) begin
                checks++;
                if (busy !== 1'b1 || ram_addr !== 10'h3FF) begin
                    errors++; $display("FAIL rd_wait got busy %b addr %h exp 1 3ff", busy, ram_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (a1.rdata !== 32'h12345678) begin
                    errors++; $display("FAIL rd_m1_rdata got %h exp 12345678", a1.rdata);
                end
                checks++;
                if (a0.rdata !== 32'h0) begin
                    errors++; $display("FAIL rd_m0_rdata got %h exp 0", a0.rdata);
                end
                a1.req = 1'b0;
            end
        end
    endtask

    task automatic test_arbitration();
        int n;
        logic got;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a0.req = 1'b1; a0.we = 1'b1; a0.addr = 10'h010; a0.wdata = 32'h0A0A0A0A;
        a1.req = 1'b1; a1.we = 1'b1; a1.addr = 10'h011; a1.wdata = 32'h0B0B0B0B;
        n = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            @(negedge clk);
            if (ram_we) begin
                checks++;
                if (ram_addr !== (n[0] ? 10'h011 : 10'h010)) begin
                    errors++; $display("FAIL arb_addr %0d got %h exp %h", n, ram_addr,
                                       n[0] ? 10'h011 : 10'h010);
                end
            end
            if (a0.ready || a1.ready) begin
                got = a1.ready;
                checks++;
                if ((a0.ready && a1.ready) || got !== n[0]) begin
                    errors++; $display("FAIL arb_order %0d got m%0d exp m%0d", n, got, n[0]);
                end
                n++;
            end
        end
        checks++;
        if (n != 8) begin errors++; $display("FAIL arb_count got %0d exp 8", n); end
        a0.req = 1'b0; a1.req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rst_wait();
        preload(10'h020, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        a0.req = 1'b1; a0.we = 1'b0; a0.addr = 10'h020;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (a0.ready !== 1'b1 || a0.rdata !== 32'hA5A5A5A5) begin
                    errors++; $display("FAIL rw_first got %b %h exp 1 a5a5a5a5", a0.ready, a0.rdata);
                end
                a0.req = 1'b0;
            end
        end
        a0.req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ram_we !== 1'b0) begin
            errors++; $display("FAIL rw_in_wait got busy %b we %b exp 1 0", busy, ram_we);
        end
        rst = 1'b1; a0.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || a0.ready !== 1'b0) begin
            errors++; $display("FAIL rw_abort got busy %b ready %b exp 0 0", busy, a0.ready);
        end
        checks++;
        if (a0.rdata !== 32'h0 || ram_we !== 1'b0) begin
            errors++; $display("FAIL rw_clear got rdata %h we %b exp 0 0", a0.rdata, ram_we);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (a0.ready !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rw_after c%0d got ready %b busy %b exp 0 0", c, a0.ready, busy);
            end
        end
    endtask

    task automatic test_lat3();
        preload(10'h007, 32'hCAFEF00D, 1'b1);
        @(negedge clk);
        b0.req = 1'b1; b0.we = 1'b0; b0.addr = 10'h007; b0.wdata = 32'h0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if (b0.ready !== (c == 5)) begin
                errors++; $display("FAIL l3_ready c%0d got %b exp %b", c, b0.ready, c == 5);
            end
            if (c <= 4) begin
                checks++;
                if (ram_addr3 !== 10'h007 || ram_we3 !== 1'b0) begin
                    errors++; $display("FAIL l3_addr c%0d got %h we %b exp 007 0", c, ram_addr3, ram_we3);
                end
            end
            if (c == 5) begin
                checks++;
                if (b0.rdata !== 32'hCAFEF00D) begin
                    errors++; $display("FAIL l3_rdata got %h exp cafef00d", b0.rdata);
                end
                b0.req = 1'b0;
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        a1.req = 1'b1; a1.we = 1'b1; a1.addr = 10'h030; a1.wdata = 32'h13572468;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (a1.ready !== (c == 2 || c == 5)) begin
                errors++; $display("FAIL hold_ready c%0d got %b exp %b", c, a1.ready, c == 2 || c == 5);
            end
            checks++;
            if (ram_we !== (c == 1 || c == 4)) begin
                errors++; $display("FAIL hold_we c%0d got %b exp %b", c, ram_we, c == 1 || c == 4);
            end
            if (c == 4) a1.req = 1'b0;
        end
        checks++;
        if (mem[10'h030] !== 32'h13572468) begin
            errors++; $display("FAIL hold_mem got %h exp 13572468", mem[10'h030]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pl_we = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
        a0.req = 1'b0; a0.we = 1'b0; a0.addr = '0; a0.wdata = '0;
        a1.req = 1'b0; a1.we = 1'b0; a1.addr = '0; a1.wdata = '0;
        b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;
        b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_rst_wait();
        test_lat3();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
